// File: rtl/bennett_phase_sequencer.sv
// Multi-phase Bennett clock generator: ramps WIDTH phase clocks up, dwells at the peak, ramps down.
// Optional feature macro BENNETT_SEQ_STALL_EN lets the stall input freeze the sequencer.
module bennett_phase_sequencer #(
  parameter int unsigned WIDTH        = 13,
  parameter int unsigned STEP_CYCLES  = 1,
  parameter int unsigned DWELL_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       continuous,
  input  logic                       stall,
  output logic [WIDTH-1:0]           clkp,
  output logic [WIDTH-1:0]           clkn,
  output logic                       busy,
  output logic                       peak_flag,
  output logic                       inst_flag,
  output logic [$clog2(WIDTH+1)-1:0] phase_idx
);
  localparam int unsigned PW   = $clog2(WIDTH + 1);
  localparam int unsigned MAXC = (STEP_CYCLES > DWELL_CYCLES) ? STEP_CYCLES : DWELL_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] STEP_LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [PW-1:0] TOP_LEVEL  = PW'(WIDTH - 1);
  localparam logic [PW-1:0] ONE_LEVEL  = PW'(1);

  if (WIDTH < 2) begin : g_bad_width
    $error("bennett_phase_sequencer: WIDTH must be >= 2");
  end
  if (STEP_CYCLES < 1) begin : g_bad_step
    $error("bennett_phase_sequencer: STEP_CYCLES must be >= 1");
  end
  if (DWELL_CYCLES < 1) begin : g_bad_dwell
    $error("bennett_phase_sequencer: DWELL_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, RAMP_UP, DWELL, RAMP_DOWN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          hold;

`ifdef BENNETT_SEQ_STALL_EN
  assign hold = stall;
`else
  logic stall_unused;
  assign hold         = 1'b0;
  assign stall_unused = stall;
`endif

  // clkn is shifted alongside clkp so it stays registered rather than decoded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      clkp      <= '0;
      clkn      <= '1;
      busy      <= 1'b0;
      peak_flag <= 1'b0;
      inst_flag <= 1'b0;
      phase_idx <= '0;
    end else begin
      peak_flag <= 1'b0;
      inst_flag <= 1'b0;
      if (!hold) begin
        case (state)
          IDLE: begin
            if (start || continuous) begin
              state     <= RAMP_UP;
              cnt       <= '0;
              clkp      <= {{(WIDTH-1){1'b0}}, 1'b1};
              clkn      <= {{(WIDTH-1){1'b1}}, 1'b0};
              busy      <= 1'b1;
              phase_idx <= ONE_LEVEL;
            end
          end
          RAMP_UP: begin
            if (cnt == STEP_LAST) begin
              cnt       <= '0;
              clkp      <= {clkp[WIDTH-2:0], 1'b1};
              clkn      <= {clkn[WIDTH-2:0], 1'b0};
              phase_idx <= phase_idx + PW'(1);
              if (phase_idx == TOP_LEVEL) begin
                state     <= DWELL;
                peak_flag <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DWELL: begin
            if (cnt == DWELL_LAST) begin
              cnt       <= '0;
              clkp      <= {1'b0, clkp[WIDTH-1:1]};
              clkn      <= {1'b1, clkn[WIDTH-1:1]};
              phase_idx <= phase_idx - PW'(1);
              state     <= RAMP_DOWN;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          RAMP_DOWN: begin
            if (cnt == STEP_LAST) begin
              cnt       <= '0;
              clkp      <= {1'b0, clkp[WIDTH-1:1]};
              clkn      <= {1'b1, clkn[WIDTH-1:1]};
              phase_idx <= phase_idx - PW'(1);
              if (phase_idx == ONE_LEVEL) begin
                state     <= IDLE;
                busy      <= 1'b0;
                inst_flag <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/bennett_phase_sequencer.md
# bennett_phase_sequencer

- Parametrised multi-phase Bennett clock generator; next generation of the fixed-width `bennett_clock`.
- Ramps a bank of WIDTH adiabatic phase clocks up one level at a time, holds them at peak, then ramps them down in reverse order.
- Adds programmable step and dwell lengths, single-shot or continuous operation, and registered peak and instruction-boundary pulses. Testbenches no longer decode the all-ones state themselves.
- Drives the clkpos/clkneg buses of the adiabatic ALU datapath and paces the instruction loop through inst_flag.

## Interface
- WIDTH, 13, number of phase clocks; must be >= 2.
- STEP_CYCLES, 1, clk cycles each intermediate level is held during the ramps; must be >= 1.
- DWELL_CYCLES, 1, clk cycles the all-ones peak is held; must be >= 1.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  requests one Bennett cycle; sampled only when idle.
- continuous  input  1  when high, cycles repeat back-to-back without start.
- stall  input  1  freezes the sequencer; only effective with BENNETT_SEQ_STALL_EN.
- clkp  output  WIDTH  positive phase clocks; bit k rises k-th and falls k-th from last.
- clkn  output  WIDTH  negative phase clocks; always the bitwise complement of clkp.
- busy  output  1  high whenever clkp is non-zero.
- peak_flag  output  1  one-cycle pulse on the first cycle clkp is all ones.
- inst_flag  output  1  one-cycle pulse on the first cycle clkp returns to zero.
- phase_idx  output  $clog2(WIDTH+1)  number of ones in clkp (0..WIDTH).

## Operation
- States:
  - IDLE: clkp=0.
  - RAMP_UP.
  - DWELL: clkp all ones.
  - RAMP_DOWN.
- IDLE -> RAMP_UP when (start | continuous) is sampled high. clkp[0] sets on that same edge.
- RAMP_UP: the current level is held STEP_CYCLES cycles, then clkp[level] sets.
  - The edge that sets clkp[WIDTH-1] enters DWELL and registers peak_flag=1.
- DWELL: lasts DWELL_CYCLES cycles, then clkp[WIDTH-1] clears and the state enters RAMP_DOWN.
- RAMP_DOWN: each level is held STEP_CYCLES cycles, then the highest set bit clears.
  - The edge that clears clkp[0] enters IDLE and registers inst_flag=1.
- The zero level always lasts at least one cycle. Bits are never set and cleared on the same edge.
- Continuous period = 2*(WIDTH-1)*STEP_CYCLES + DWELL_CYCLES + 1 cycles (26 for the defaults).
- Outputs registered from state: clkn = ~clkp; busy = (clkp != 0); phase_idx = level count.
- start while busy is ignored and not queued.
- Deasserting continuous mid-cycle lets the current cycle complete; the sequencer then remains in IDLE.
- Parameter violations raise $error at elaboration.

## Timing
- Reset values (asynchronous, take effect immediately):
  - clkp=0, clkn=all ones.
  - busy=0, peak_flag=0, inst_flag=0, phase_idx=0.
  - State IDLE, step counter 0.
- Reset mid-ramp collapses clkp to 0 at once. This is non-adiabatic and permitted only for power-up and debug.
- Latency from start sampled high in IDLE to clkp[0]=1 is one edge.
- With STEP=1, DWELL=1, WIDTH=4 and start at cycle 0, clkp per edge 1..8 is:
  - 0001, 0011, 0111, 1111 (peak_flag), 0111, 0011, 0001, 0000 (inst_flag).
- peak_flag and inst_flag are exactly one cycle wide and never re-pulse while the level is held.
- Restart: if start or continuous is high in the inst_flag cycle, clkp[0] sets on the next edge.

## Configuration
- BENNETT_SEQ_STALL_EN defined:
  - stall=1 freezes state, clkp/clkn, counters and phase_idx.
  - Any pending level change is deferred; flags fall after their one cycle and fire only on the deferred transition edge.
  - stall in IDLE blocks acceptance of start and continuous.
- BENNETT_SEQ_STALL_EN undefined: the stall port is present but ignored, and the sequencer never pauses.

## Test plan
- Single shot, defaults:
  - Stimulus: start pulse.
  - Response: clkp 1,3,7,...,0x1FFF over 13 edges; peak_flag at edge 13; all ones held 1 cycle; ramp back to 0 with inst_flag at edge 26; busy low afterwards; clkn==~clkp every cycle.
- Continuous, WIDTH=4, STEP=2, DWELL=3:
  - Stimulus: continuous held high.
  - Response: inst_flag period 2*3*2+3+1=16 cycles; each intermediate level held 2 cycles; peak held 3 cycles; phase_idx tracks popcount.
- start during RAMP_UP and at the peak:
  - Response: no extra cycle, no period change.
  - Then start in the inst_flag cycle: clkp[0]=1 on the next edge.
- Async reset asserted when phase_idx=7 between clk edges:
  - Response: clkp=0, clkn=0x1FFF and flags 0 immediately, before the next edge; start after release begins a clean cycle.
- With BENNETT_SEQ_STALL_EN, stall=1 for 5 cycles at level 12:
  - Response: clkp stays 0x0FFF; peak_flag fires once, on the first edge after stall drops.
  - Without the macro, the same stimulus gives an unchanged 26-cycle timeline.
